mem_arbiter: RTL

Two-port memory arbiter for the RV32I core. It shares one memory port between the instruction-fetch requester and the load/store requester. Downstream of the arbiter, the memory controller handles byte-lane and sign-extension work. The arbiter does not interpret transfer contents: it arbitrates, registers the memory-side strobes, waits for the memory's ready, and returns a registered response to the winner.

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single memory port between the instruction-fetch
// requester and the load/store requester. Data normally wins; a streak
// counter lets a waiting fetch through after MAX_D_STREAK data grants.
// All memory-side strobes, acks and read data are registered.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a transfer whose
// mem_ready has not arrived within TIMEOUT_CYCLES busy cycles (err=1).
module mem_arbiter #(
   parameter int MAX_D_STREAK   = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic        mem_r,
   output logic [3:0]  mem_w,
   output logic [31:0] mem_dw,
   input  logic [31:0] mem_dr,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   localparam int             SW         = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);

   // Reject configurations the counters cannot represent.
   if (MAX_D_STREAK < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("mem_arbiter: MAX_D_STREAK must be >= 1 and TIMEOUT_CYCLES >= 2");
   end

   state_t        r_state;
   state_t        w_state_next;
   logic [SW-1:0] r_streak;
   logic          r_if_ack;
   logic          r_d_ack;
   logic [31:0]   r_if_rdata;
   logic [31:0]   r_d_rdata;
   logic [31:0]   r_mem_addr;
   logic          r_mem_r;
   logic [3:0]    r_mem_w;
   logic [31:0]   r_mem_dw;

   logic          w_if_pend;
   logic          w_d_pend;
   logic          w_grant_i;
   logic          w_grant_d;
   logic          w_done;
   logic          w_abort;
   logic          w_finish;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int            TW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] r_tmo;
   logic          r_err;
`endif

   // A requester whose ack is high this cycle is still holding its old
   // request, so it is not a candidate for a new grant.
   assign w_if_pend = if_req & ~r_if_ack;
   assign w_d_pend  = d_req & ~r_d_ack;
   assign w_finish  = w_done | w_abort;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state, arbitration and completion decode
   always_comb begin
      w_state_next = r_state;
      w_grant_i    = 1'b0;
      w_grant_d    = 1'b0;
      w_done       = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_d_pend && !(w_if_pend && (r_streak == STREAK_MAX))) begin
               w_grant_d    = 1'b1;
               w_state_next = BUSY_D;
            end else if (w_if_pend) begin
               w_grant_i    = 1'b1;
               w_state_next = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
`ifdef MEM_ARB_TIMEOUT_EN
            // The abort cycle wins over a late mem_ready.
            if (r_tmo == TO_LAST) begin
               w_abort = 1'b1;
            end else if (mem_ready) begin
               w_done = 1'b1;
            end
`else
            if (mem_ready) begin
               w_done = 1'b1;
            end
`endif
            if (w_done || w_abort) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Data-grant streak: counts data wins taken while a fetch was waiting
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_streak <= '0;
      end else if (w_grant_d) begin
         if (!w_if_pend) begin
            r_streak <= '0;
         end else if (r_streak != STREAK_MAX) begin
            r_streak <= r_streak + SW'(1);
         end
      end else if (w_grant_i) begin
         r_streak <= '0;
      end
   end

   // Memory strobes, captured read data and one-cycle acks
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem_addr <= '0;
         r_mem_r    <= 1'b0;
         r_mem_w    <= 4'b0000;
         r_mem_dw   <= '0;
         r_if_ack   <= 1'b0;
         r_d_ack    <= 1'b0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         r_if_ack <= 1'b0;
         r_d_ack  <= 1'b0;
         if (w_grant_d) begin
            r_mem_addr <= d_addr;
            r_mem_r    <= (d_we == 4'b0000);
            r_mem_w    <= d_we;
            r_mem_dw   <= d_wdata;
         end else if (w_grant_i) begin
            r_mem_addr <= if_addr;
            r_mem_r    <= 1'b1;
            r_mem_w    <= 4'b0000;
         end else if (w_finish) begin
            r_mem_r <= 1'b0;
            r_mem_w <= 4'b0000;
         end
         if (w_finish) begin
            if (r_state == BUSY_I) begin
               r_if_ack   <= 1'b1;
               r_if_rdata <= w_abort ? 32'h0 : mem_dr;
            end else begin
               r_d_ack   <= 1'b1;
               r_d_rdata <= w_abort ? 32'h0 : mem_dr;
            end
         end
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   // Busy-cycle counter; restarts with every grant
   always_ff @(posedge clk) begin
      if (!rst_n || w_grant_i || w_grant_d) begin
         r_tmo <= '0;
      end else if (r_state != IDLE && r_tmo != TO_LAST) begin
         r_tmo <= r_tmo + TW'(1);
      end
   end

   // err accompanies the ack that follows an abort
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_abort;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign if_ack   = r_if_ack;
   assign d_ack    = r_d_ack;
   assign if_rdata = r_if_rdata;
   assign d_rdata  = r_d_rdata;
   assign mem_addr = r_mem_addr;
   assign mem_r    = r_mem_r;
   assign mem_w    = r_mem_w;
   assign mem_dw   = r_mem_dw;

endmodule
